// File: rtl/cpu_pkg.sv
// Shared constants for the CPU memory arbiter: default widths, FSM encoding, port ids.
package cpu_pkg;
    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way request picker; arbitration policy selected by MEM_ARB_RR_EN
// (defined: round-robin on contention, undefined: port 0 fixed priority).
module arb_pick
    import cpu_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_id,
    output logic gnt_vld
);

    always_comb begin
        gnt_vld = req0 | req1;
`ifdef MEM_ARB_RR_EN
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = req0 ? PORT_CPU : PORT_DBG;
        end
`else
        gnt_id = req0 ? PORT_CPU : PORT_DBG;
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores grant history.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (port 0) and debug (port 1) accesses to the single-port program/data memory.
// Build option MEM_ARB_RR_EN selects round-robin arbitration instead of CPU fixed priority.
//
// state     | meaning
// ST_IDLE   | sample requests, latch the winner's access
// ST_ACCESS | memory strobe for the latched access
// ST_RESP   | read data returned, ack pulse to latched requester
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    arb_state_t        state, state_d;
    logic              gnt_id, gnt_vld, last_gnt;
    logic              grant, rd_d, wr_d, ack0_d, ack1_d, capture;
    logic              lat_id, lat_we;
    logic [DWIDTH-1:0] rdata_q;
    logic              sel_we;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_q;
    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = PORT_DBG;
`endif

    arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt_id   (gnt_id),
        .gnt_vld  (gnt_vld)
    );

    assign sel_we    = (gnt_id == PORT_DBG) ? we1    : we0;
    assign sel_addr  = (gnt_id == PORT_DBG) ? addr1  : addr0;
    assign sel_wdata = (gnt_id == PORT_DBG) ? wdata1 : wdata0;

    // Memory data is only valid during RESP, so the ack-cycle value bypasses the holding register.
    assign rdata = capture ? mem_rdata : rdata_q;

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    grant   = 1'b1;
                    rd_d    = ~sel_we;
                    wr_d    = sel_we;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ack0_d  = (lat_id == PORT_CPU);
                ack1_d  = (lat_id == PORT_DBG);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                capture = ~lat_we;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            lat_id    <= PORT_CPU;
            lat_we    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= PORT_DBG;
`endif
        end else begin
            state  <= state_d;
            mem_rd <= rd_d;
            mem_wr <= wr_d;
            ack0   <= ack0_d;
            ack1   <= ack1_d;
            if (grant) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                lat_id    <= gnt_id;
                lat_we    <= sel_we;
`ifdef MEM_ARB_RR_EN
                last_gnt_q <= gnt_id;
`endif
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner-case sequences and random traffic
// checked against a transaction-level model (memory image + grant history).
module tb_mem_arbiter;
    import cpu_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0, we0, req1, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, mem_rd, mem_wr;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Registered single-port memory
    logic [7:0] mem [32];
    logic [7:0] mem_q;
    assign mem_rdata = mem_q;
    always @(posedge CLK) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_q <= mem[mem_addr];
    end

    int         total = 0;
    int         bad   = 0;
    logic [7:0] ref_img [32];
    logic       m_last = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            check("excl_strobe", {31'd0, mem_rd & mem_wr}, 32'd0);
            check("excl_ack", {31'd0, ack0 & ack1}, 32'd0);
        end
    end

    // Model: serve the winner first, then the other port; updates image and grant history.
    task automatic model_txn(input bit en0, input bit en1,
                             input bit w0, input logic [4:0] a0, input logic [7:0] d0,
                             input bit w1, input logic [4:0] a1, input logic [7:0] d1,
                             output bit first, output logic [7:0] e0, output logic [7:0] e1);
        bit p;
        e0 = 8'h00;
        e1 = 8'h00;
        if (en0 && en1) first = RR ? ~m_last : 1'b0;
        else            first = en1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : ~first;
            if ((p == 1'b0 && en0) || (p == 1'b1 && en1)) begin
                if (p == 1'b0) begin
                    if (w0) ref_img[a0] = d0; else e0 = ref_img[a0];
                end else begin
                    if (w1) ref_img[a1] = d1; else e1 = ref_img[a1];
                end
                m_last = p;
            end
        end
    endtask

    // Drive one or two requests (starting just after a clock edge with DUT idle) and check the outcome.
    task automatic run_txn(input bit en0, input bit en1,
                           input bit w0, input logic [4:0] a0, input logic [7:0] d0,
                           input bit w1, input logic [4:0] a1, input logic [7:0] d1,
                           input bit first, input logic [7:0] e0, input logic [7:0] e1,
                           input string nm);
        int c0, c1, last;
        c0 = -10;
        c1 = -10;
        if (en0 && en1) begin
            c0 = first ? 5 : 2;
            c1 = first ? 2 : 5;
        end else begin
            if (en0) c0 = 2;
            if (en1) c1 = 2;
        end
        last = (c0 > c1) ? c0 : c1;
        req0 = en0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = en1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge CLK);
            if (c == c0 - 1) begin
                check({nm, "_strobe0"}, {25'd0, ~w0, w0, mem_addr}, {25'd0, ~w0, w0, a0});
                if (w0) check({nm, "_wdata0"}, {24'd0, mem_wdata}, {24'd0, d0});
            end
            if (c == c1 - 1) begin
                check({nm, "_strobe1"}, {25'd0, ~w1, w1, mem_addr}, {25'd0, ~w1, w1, a1});
                if (w1) check({nm, "_wdata1"}, {24'd0, mem_wdata}, {24'd0, d1});
            end
            check({nm, "_ack0"}, {31'd0, ack0}, {31'd0, c == c0});
            check({nm, "_ack1"}, {31'd0, ack1}, {31'd0, c == c1});
            if (c == c0 && !w0) check({nm, "_rdata0"}, {24'd0, rdata}, {24'd0, e0});
            if (c == c1 && !w1) check({nm, "_rdata1"}, {24'd0, rdata}, {24'd0, e1});
            @(posedge CLK);
            #1;
            if (c == c0) req0 = 1'b0;
            if (c == c1) req1 = 1'b0;
        end
    endtask

    task automatic txn(input bit en0, input bit en1,
                       input bit w0, input logic [4:0] a0, input logic [7:0] d0,
                       input bit w1, input logic [4:0] a1, input logic [7:0] d1, input string nm);
        bit         first;
        logic [7:0] e0, e1;
        model_txn(en0, en1, w0, a0, d0, w1, a1, d1, first, e0, e1);
        run_txn(en0, en1, w0, a0, d0, w1, a1, d1, first, e0, e1, nm);
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit         first, p, got;
        logic [7:0] e0, e1, img;
        int         n, prev;

        vecs[0] = '{1'b1, 1'b1, 5'h03, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 5'h03, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b0, 5'h17, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 5'h1F, 8'h5A, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 5'h1F, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h11};

        RST = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_outs", {20'd0, ack0, ack1, mem_rd, mem_wr, rdata}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
`ifdef MEM_ARB_RR_EN
        check("rst_last_gnt", {31'd0, dut.last_gnt_q}, 32'd1);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Loader preload through the debug port
        for (int i = 0; i < 32; i++) begin
            img = 8'($urandom);
            if (i == 5'h17) img = 8'h3C;
            if (i == 0)     img = 8'h11;
            txn(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 5'(i), img, $sformatf("preload%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            model_txn(!vecs[i].port, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].we, vecs[i].addr, vecs[i].wdata, first, e0, e1);
            run_txn(!vecs[i].port, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].we, vecs[i].addr, vecs[i].wdata, first, vecs[i].exp, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Both ports held: fixed priority serves only CPU; round-robin alternates
        req0 = 1; we0 = 0; addr0 = 5'h01;
        req1 = 1; we1 = 0; addr1 = 5'h02;
        p = m_last;
        for (int c = 0; c < 18; c++) begin
            @(negedge CLK);
            if (c % 3 == 2) p = RR ? ~p : 1'b0;
            check($sformatf("contend_ack0_c%0d", c), {31'd0, ack0}, {31'd0, (c % 3 == 2) && !p});
            check($sformatf("contend_ack1_c%0d", c), {31'd0, ack1}, {31'd0, (c % 3 == 2) && p});
            if (c % 3 == 2)
                check($sformatf("contend_rdata_c%0d", c), {24'd0, rdata},
                      {24'd0, p ? ref_img[5'h02] : ref_img[5'h01]});
            @(posedge CLK);
            #1;
        end
        m_last = p;
        req0 = 0;
        req1 = 0;
        @(negedge CLK);
        check("contend_drain", {30'd0, ack0, ack1}, 32'd0);
        @(posedge CLK);
        #1;

        // Reset during ACCESS of a CPU write
        req0 = 1; we0 = 1; addr0 = 5'h0A; wdata0 = 8'h77;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rstmid_strobe", {27'd0, mem_wr, mem_addr}, {27'd0, 1'b1, 5'h0A});
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        req0 = 0;
        ref_img[5'h0A] = 8'h77;
        m_last = 1'b1;
        @(negedge CLK);
        check("rstmid_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        check("rstmid_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rstmid_noack%0d", c), {30'd0, ack0, ack1}, 32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        txn(1'b1, 1'b0, 1'b1, 5'h0A, 8'h78, 1'b0, 5'd0, 8'd0, "rstmid_rewr");
        txn(1'b1, 1'b0, 1'b0, 5'h0A, 8'h00, 1'b0, 5'd0, 8'd0, "rstmid_rerd");

        // Debug read with req dropped during ACCESS
        req1 = 1; we1 = 0; addr1 = 5'h03;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        req1 = 0;
        @(negedge CLK);
        check("drop_strobe", {26'd0, mem_rd, mem_wr, mem_addr}, {26'd0, 1'b1, 1'b0, 5'h03});
        @(negedge CLK);
        check("drop_ack1", {30'd0, ack0, ack1}, 32'd1);
        check("drop_rdata", {24'd0, rdata}, {24'd0, ref_img[5'h03]});
        m_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check($sformatf("drop_idle%0d", c), {28'd0, mem_rd, mem_wr, ack0, ack1}, 32'd0);
        end
        @(posedge CLK);
        #1;

        // Back-to-back CPU reads of the whole image, 3-cycle spacing
        req0 = 1; we0 = 0; addr0 = 5'h00;
        n = 0;
        prev = -1;
        for (int c = 0; c < 110 && n < 32; c++) begin
            @(negedge CLK);
            got = ack0;
            if (got) begin
                check($sformatf("b2b_rdata%0d", n), {24'd0, rdata}, {24'd0, ref_img[addr0]});
                check($sformatf("b2b_space%0d", n), c - prev, 3);
                prev = c;
                n++;
            end
            @(posedge CLK);
            #1;
            if (got) begin
                if (n == 32) req0 = 0;
                else addr0 = 5'(n);
            end
        end
        req0 = 0;
        check("b2b_count", n, 32);
        m_last = 1'b0;

        // Random traffic, single and contended
        for (int i = 0; i < 40; i++) begin
            int         mode;
            bit         rw0, rw1;
            logic [4:0] ra0, ra1;
            logic [7:0] rd0, rd1;
            mode = $urandom_range(0, 2);
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            ra0 = 5'($urandom); ra1 = 5'($urandom);
            rd0 = 8'($urandom); rd1 = 8'($urandom);
            txn(mode != 1, mode != 0, rw0, ra0, rd0, rw1, ra1, rd1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
